// File: rtl/affine_pkg.sv
// Shared types and iterator-step helper for the affine-scheduled op streams.
package affine_pkg;

  localparam int unsigned W = 16;

  typedef logic [W-1:0] idx_t;

  typedef enum logic [1:0] {
    WAIT,
    RUN,
    DONE
  } chk_state_t;

  typedef struct packed {
    idx_t ey;
    idx_t ex;
    idx_t et;
  } affine_iter_t;

  // One step of the 2-D loop nest; et is carried incrementally so no multiply is needed.
  function automatic affine_iter_t affine_next(idx_t ey, idx_t ex, idx_t et,
                                               idx_t extent_x, idx_t stride_y);
    affine_iter_t n;
    if (ex == extent_x - idx_t'(1)) begin
      n.ey = ey + idx_t'(1);
      n.ex = '0;
      n.et = et + stride_y - extent_x + idx_t'(1);
    end else begin
      n.ey = ey;
      n.ex = ex + idx_t'(1);
      n.et = et + idx_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/affine_expect_gen.sv
// Expected loop-nest iterator (ey, ex, et) for the consumer-side stream checker.
module affine_expect_gen
  import affine_pkg::*;
#(
  parameter int unsigned OFFSET   = 415,
  parameter int unsigned STRIDE_Y = 64,
  parameter int unsigned EXTENT_Y = 58,
  parameter int unsigned EXTENT_X = 58
) (
  input  logic clk,
  input  logic clear_i,
  input  logic advance_i,
  output idx_t ey_o,
  output idx_t ex_o,
  output idx_t et_o,
  output logic last_c
);

  affine_iter_t iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (advance_i) begin
      iter_d = affine_next(iter_q.ey, iter_q.ex, iter_q.et,
                           idx_t'(EXTENT_X), idx_t'(STRIDE_Y));
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      iter_q <= '{ey: '0, ex: '0, et: idx_t'(OFFSET)};
    end else begin
      iter_q <= iter_d;
    end
  end

  assign ey_o   = iter_q.ey;
  assign ex_o   = iter_q.ex;
  assign et_o   = iter_q.et;
  assign last_c = (iter_q.ey == idx_t'(EXTENT_Y - 1)) && (iter_q.ex == idx_t'(EXTENT_X - 1));

endmodule

// File: rtl/affine_stream_checker.sv
// Receives a valid/d[2:0] iteration stream, generates buffer write address/enable,
// and flags index, timing and overrun errors against the expected affine schedule.
module affine_stream_checker
  import affine_pkg::idx_t, affine_pkg::chk_state_t, affine_pkg::WAIT,
         affine_pkg::RUN, affine_pkg::DONE;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned OFFSET    = 415,
  parameter int unsigned STRIDE_Y  = 64,
  parameter int unsigned EXTENT_Y  = 58,
  parameter int unsigned EXTENT_X  = 58,
  parameter int unsigned ROW_PITCH = 58,
  parameter int unsigned BASE      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [2:0][W-1:0]   in_d,
  output logic                wen,
  output logic [W-1:0]        addr,
  output logic                done,
  output logic                err_index,
  output logic                err_timing,
  output logic [W-1:0]        count
);

  logic           clear;
  logic           advance_c;
  logic           last_c;
  idx_t           ey, ex, et;
  logic [W-1:0]   ey_w, ex_w, et_w;

  chk_state_t     state_q, state_d;
  logic [W-1:0]   t_q, t_d;
  logic           wen_q, wen_d;
  logic [W-1:0]   addr_q, addr_d;
  logic           done_q, done_d;
  logic           err_index_q, err_index_d;
  logic           err_timing_q, err_timing_d;
  logic [W-1:0]   count_q, count_d;

  assign clear = rst | flush;
  assign ey_w  = W'(ey);
  assign ex_w  = W'(ex);
  assign et_w  = W'(et);

  affine_expect_gen #(
    .OFFSET   (OFFSET),
    .STRIDE_Y (STRIDE_Y),
    .EXTENT_Y (EXTENT_Y),
    .EXTENT_X (EXTENT_X)
  ) u_expect (
    .clk       (clk),
    .clear_i   (clear),
    .advance_i (advance_c),
    .ey_o      (ey),
    .ex_o      (ex),
    .et_o      (et),
    .last_c    (last_c)
  );

  // Next-state, checks and write generation; at most one iterator advance per cycle.
  always_comb begin
    state_d      = state_q;
    t_d          = (t_q == '1) ? t_q : t_q + W'(1);
    advance_c    = 1'b0;
    wen_d        = 1'b0;
    addr_d       = addr_q;
    done_d       = done_q;
    err_index_d  = err_index_q;
    err_timing_d = err_timing_q;
    count_d      = count_q;
    case (state_q)
      WAIT, RUN: begin
        if (state_q == WAIT && t_q == W'(OFFSET)) state_d = RUN;
        if (in_valid) begin
          advance_c = 1'b1;
          wen_d     = 1'b1;
          addr_d    = W'(BASE) + W'(ROW_PITCH) * in_d[1] + in_d[2];
          count_d   = count_q + W'(1);
          if (in_d[0] != '0 || in_d[1] != ey_w || in_d[2] != ex_w) err_index_d = 1'b1;
          if (t_q != et_w) err_timing_d = 1'b1;
        end else if (t_q >= et_w) begin
          // slot due with nothing received: flag it and skip to the next slot
          advance_c    = 1'b1;
          err_timing_d = 1'b1;
        end
        if (advance_c && last_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (in_valid) err_index_d = 1'b1;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= WAIT;
      t_q          <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      err_index_q  <= 1'b0;
      err_timing_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      err_index_q  <= err_index_d;
      err_timing_q <= err_timing_d;
      count_q      <= count_d;
    end
  end

  assign wen        = wen_q;
  assign addr       = addr_q;
  assign done       = done_q;
  assign err_index  = err_index_q;
  assign err_timing = err_timing_q;
  assign count      = count_q;

endmodule

// File: tb/tb_affine_stream_checker.sv
// Directed bench for affine_stream_checker at default parameters.
module tb_affine_stream_checker;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [2:0][15:0] in_d;
  logic             wen;
  logic [15:0]      addr;
  logic             done;
  logic             err_index;
  logic             err_timing;
  logic [15:0]      count;

  int checks   = 0;
  int failures = 0;

  int n_wen, first_wen_c, first_wen_addr, last_addr, done_c, ei_c, et_c, bad_addr, wen_in_done;
  logic [50:0] snap;

  affine_stream_checker dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_d       (in_d),
    .wen        (wen),
    .addr       (addr),
    .done       (done),
    .err_index  (err_index),
    .err_timing (err_timing),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    n_wen = 0; first_wen_c = -1; first_wen_addr = -1; last_addr = -1;
    done_c = -1; ei_c = -1; et_c = -1; bad_addr = -1; wen_in_done = 0;
  endtask

  // Leaves the bench in cycle 0 (first cycle after reset released).
  task automatic drive_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_d = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Controller-timed producer with optional drop, corrupted x, extra tokens and mid-run rst/flush.
  task automatic run_stream(input int drop_c, input int bad_c, input int bad_x,
                            input int x1_c, input int x2_c, input int rst_c,
                            input int flush_c, input int end_c);
    int base, rel, y, x;
    logic prev_done;
    clear_stats();
    snap = '1;
    prev_done = 1'b0;
    for (int c = 0; c <= end_c; c++) begin
      if ((rst_c >= 0 && c == rst_c + 1) || (flush_c >= 0 && c == flush_c + 1)) begin
        snap = {wen, addr, done, err_index, err_timing, count};
        clear_stats();
        prev_done = 1'b0;
      end
      if (wen) begin
        if (n_wen == 0) begin first_wen_c = c; first_wen_addr = int'(addr); end
        n_wen++;
        last_addr = int'(addr);
        if (prev_done) wen_in_done++;
      end
      if (done && done_c < 0) done_c = c;
      if (err_index && ei_c < 0) ei_c = c;
      if (err_timing && et_c < 0) et_c = c;
      if (bad_c >= 0 && c == bad_c + 1) bad_addr = int'(addr);
      prev_done = done;

      base = (rst_c >= 0 && c > rst_c) ? rst_c + 1 :
             (flush_c >= 0 && c > flush_c) ? flush_c + 1 : 0;
      rel = c - base - 415;
      rst = (c == rst_c);
      flush = (c == flush_c);
      in_valid = 1'b0;
      in_d = '0;
      if (rel >= 0 && c != rst_c && c != flush_c) begin
        y = rel / 64;
        x = rel % 64;
        if (y < 58 && x < 58 && c != drop_c) begin
          in_valid = 1'b1;
          in_d[1] = 16'(y);
          in_d[2] = (c == bad_c) ? 16'(bad_x) : 16'(x);
        end
      end
      if (c == x1_c || c == x2_c) begin
        in_valid = 1'b1;
        in_d = '0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_d = '0; rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    drive_reset();
    checks++; if (wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %0b expected 0", wen); end
    checks++; if (addr !== 16'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if ({err_index, err_timing} !== 2'b00) begin failures++; $display("FAIL reset_errs: got %0b expected 00", {err_index, err_timing}); end
    checks++; if (count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
  endtask

  task automatic test_matched();
    drive_reset();
    run_stream(-1, -1, 0, -1, -1, -1, -1, 4130);
    checks++; if (n_wen != 3364) begin failures++; $display("FAIL matched_nwen: got %0d expected 3364", n_wen); end
    checks++; if (first_wen_c != 416) begin failures++; $display("FAIL matched_first_wen: got %0d expected 416", first_wen_c); end
    checks++; if (first_wen_addr != 0) begin failures++; $display("FAIL matched_first_addr: got %0d expected 0", first_wen_addr); end
    checks++; if (last_addr != 3363) begin failures++; $display("FAIL matched_last_addr: got %0d expected 3363", last_addr); end
    checks++; if (done_c != 4121) begin failures++; $display("FAIL matched_done_cycle: got %0d expected 4121", done_c); end
    checks++; if ({err_index, err_timing} !== 2'b00) begin failures++; $display("FAIL matched_errs: got %0b expected 00", {err_index, err_timing}); end
    checks++; if (count !== 16'd3364) begin failures++; $display("FAIL matched_count: got %0d expected 3364", count); end
  endtask

  task automatic test_dropped();
    drive_reset();
    run_stream(617, -1, 0, -1, -1, -1, -1, 4130);
    checks++; if (et_c != 618) begin failures++; $display("FAIL drop_err_timing_cycle: got %0d expected 618", et_c); end
    checks++; if (ei_c != -1) begin failures++; $display("FAIL drop_err_index: got first cycle %0d expected never", ei_c); end
    checks++; if (done_c != 4121) begin failures++; $display("FAIL drop_done_cycle: got %0d expected 4121", done_c); end
    checks++; if (count !== 16'd3363) begin failures++; $display("FAIL drop_count: got %0d expected 3363", count); end
    checks++; if (n_wen != 3363) begin failures++; $display("FAIL drop_nwen: got %0d expected 3363", n_wen); end
  endtask

  task automatic test_bad_index();
    drive_reset();
    run_stream(-1, 480, 2, -1, -1, -1, -1, 4130);
    checks++; if (ei_c != 481) begin failures++; $display("FAIL bad_err_index_cycle: got %0d expected 481", ei_c); end
    checks++; if (bad_addr != 60) begin failures++; $display("FAIL bad_addr: got %0d expected 60", bad_addr); end
    checks++; if (et_c != -1) begin failures++; $display("FAIL bad_err_timing: got first cycle %0d expected never", et_c); end
    checks++; if (done_c != 4121) begin failures++; $display("FAIL bad_done_cycle: got %0d expected 4121", done_c); end
  endtask

  task automatic test_early_overrun();
    drive_reset();
    run_stream(-1, -1, 0, 10, -1, -1, -1, 20);
    checks++; if (et_c != 11) begin failures++; $display("FAIL early_err_timing_cycle: got %0d expected 11", et_c); end
    checks++; if (ei_c != -1) begin failures++; $display("FAIL early_err_index: got first cycle %0d expected never", ei_c); end
    checks++; if (first_wen_c != 11) begin failures++; $display("FAIL early_wen_cycle: got %0d expected 11", first_wen_c); end
    checks++; if (count !== 16'd1) begin failures++; $display("FAIL early_count: got %0d expected 1", count); end
    drive_reset();
    run_stream(-1, -1, 0, -1, 4125, -1, -1, 4130);
    checks++; if (ei_c != 4126) begin failures++; $display("FAIL overrun_err_index_cycle: got %0d expected 4126", ei_c); end
    checks++; if (wen_in_done != 0) begin failures++; $display("FAIL overrun_wen: got %0d pulses expected 0", wen_in_done); end
    checks++; if (count !== 16'd3364) begin failures++; $display("FAIL overrun_count: got %0d expected 3364", count); end
    checks++; if (err_timing !== 1'b0) begin failures++; $display("FAIL overrun_err_timing: got %0b expected 0", err_timing); end
  endtask

  task automatic test_reset_mid_run();
    drive_reset();
    run_stream(-1, -1, 0, -1, -1, 2000, -1, 6131);
    checks++; if (snap !== '0) begin failures++; $display("FAIL rstmid_outputs: got %h expected 0", snap); end
    checks++; if (n_wen != 3364) begin failures++; $display("FAIL rstmid_nwen: got %0d expected 3364", n_wen); end
    checks++; if (first_wen_c != 2417) begin failures++; $display("FAIL rstmid_first_wen: got %0d expected 2417", first_wen_c); end
    checks++; if (done_c != 6122) begin failures++; $display("FAIL rstmid_done_cycle: got %0d expected 6122", done_c); end
    checks++; if ({err_index, err_timing} !== 2'b00) begin failures++; $display("FAIL rstmid_errs: got %0b expected 00", {err_index, err_timing}); end
    checks++; if (count !== 16'd3364) begin failures++; $display("FAIL rstmid_count: got %0d expected 3364", count); end
  endtask

  task automatic test_flush();
    drive_reset();
    run_stream(-1, -1, 0, -1, -1, -1, 2000, 6131);
    checks++; if (snap !== '0) begin failures++; $display("FAIL flush_outputs: got %h expected 0", snap); end
    checks++; if (n_wen != 3364) begin failures++; $display("FAIL flush_nwen: got %0d expected 3364", n_wen); end
    checks++; if (done_c != 6122) begin failures++; $display("FAIL flush_done_cycle: got %0d expected 6122", done_c); end
    checks++; if ({err_index, err_timing} !== 2'b00) begin failures++; $display("FAIL flush_errs: got %0b expected 00", {err_index, err_timing}); end
    checks++; if (last_addr != 3363) begin failures++; $display("FAIL flush_last_addr: got %0d expected 3363", last_addr); end
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    checks++; if ({wen, addr, done, count} !== '0) begin failures++; $display("FAIL rst_flush_both: got %h expected 0", {wen, addr, done, count}); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_d = '0;
    test_reset();
    test_matched();
    test_dropped();
    test_bad_index();
    test_early_overrun();
    test_reset_mid_run();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
